// File: rtl/seq_110_gen.sv
// rtl/seq_110_gen.sv - Moore FSM emitting count back-to-back "110" frames on a serial line.
// Define SEQ_110_GEN_GAP_EN to insert GAP_LEN idle cycles between frames.
module seq_110_gen #(
  parameter int GAP_LEN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] count,
  input  logic       abort,
  output logic       dout,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] frames_sent
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B1   = 3'd1,
    B2   = 3'd2,
    B0   = 3'd3,
`ifdef SEQ_110_GEN_GAP_EN
    GAP  = 3'd5,
`endif
    DONE = 3'd4
  } state_t;

  state_t     state, state_next;
  logic [3:0] remaining;
  logic       accept;

  assign accept = (state == IDLE) && start && (count != 4'd0);

`ifdef SEQ_110_GEN_GAP_EN
  logic [3:0] gap_cnt;
`else
  localparam int unused_gap_len = GAP_LEN;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = B1;
      B1:   state_next = B2;
      B2:   state_next = B0;
      B0: begin
        // remaining still holds the pre-decrement value here
        if (remaining > 4'd1) begin
`ifdef SEQ_110_GEN_GAP_EN
          state_next = GAP;
`else
          state_next = B1;
`endif
        end else begin
          state_next = DONE;
        end
      end
`ifdef SEQ_110_GEN_GAP_EN
      GAP:  if (gap_cnt <= 4'd1) state_next = B1;
`endif
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= 4'd0;
      frames_sent <= 4'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        remaining   <= count;
        frames_sent <= 4'd0;
      end else if ((state == B0) && !abort) begin
        frames_sent <= frames_sent + 4'd1;
        if (remaining != 4'd0) remaining <= remaining - 4'd1;
      end
    end
  end

`ifdef SEQ_110_GEN_GAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= 4'd0;
    end else if ((state == B0) && (state_next == GAP)) begin
      gap_cnt <= 4'(GAP_LEN);
    end else if ((state == GAP) && (gap_cnt != 4'd0)) begin
      gap_cnt <= gap_cnt - 4'd1;
    end
  end
`endif

  always_comb begin
    dout  = 1'b0;
    valid = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    case (state)
      IDLE: busy = 1'b0;
      B1: begin
        dout  = 1'b1;
        valid = 1'b1;
      end
      B2: begin
        dout  = 1'b1;
        valid = 1'b1;
      end
      B0:   valid = 1'b1;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_110_gen.sv
// tb/tb_seq_110_gen.sv - self-checking bench for seq_110_gen.
module tb_seq_110_gen;
  localparam int GAP_LEN = 2;
`ifdef SEQ_110_GEN_GAP_EN
  localparam int G = GAP_LEN;
`else
  localparam int G = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] count = 4'd0;
  logic       dout, valid, busy, done;
  logic [3:0] frames_sent;

  seq_110_gen #(.GAP_LEN(GAP_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .abort(abort),
    .dout(dout), .valid(valid), .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] q[$];

  // reference non-overlapping 110 Moore detector
  logic [1:0] ds = 2'd0;
  int det_cnt = 0;
  always @(posedge clk) begin
    if (ds == 2'd3) det_cnt <= det_cnt + 1;
    case (ds)
      2'd0: ds <= dout ? 2'd1 : 2'd0;
      2'd1: ds <= dout ? 2'd2 : 2'd0;
      2'd2: ds <= dout ? 2'd2 : 2'd3;
      default: ds <= dout ? 2'd1 : 2'd0;
    endcase
  end

  typedef struct {
    int cnt;
    int abort_at;
    int busy_start;
    bit start_abort;
    int exp_fs;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [7:0] obs();
    return {dout, valid, busy, done, frames_sent};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {dout,valid,busy,done,fs}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic push_model(input int n);
    for (int f = 0; f < n; f++) begin
      q.push_back({4'b1110, 4'(f)});
      q.push_back({4'b1110, 4'(f)});
      q.push_back({4'b0110, 4'(f)});
      if (f < n - 1)
        for (int g = 0; g < G; g++) q.push_back({4'b0010, 4'(f + 1)});
    end
    q.push_back({4'b0011, 4'(n)});
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int c;
    int len;
    logic [7:0] e;
    push_model(v.cnt);
    len = q.size();
    start = 1'b1;
    count = 4'(v.cnt);
    abort = v.start_abort;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    count = 4'd0;
    c = 1;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(name, obs(), e);
      if (c == v.abort_at) begin
        abort = 1'b1;
        q.delete();
      end
      if (c == v.busy_start || (v.busy_start < 0 && c == len)) begin
        start = 1'b1;
        count = 4'd15;
      end
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      count = 4'd0;
      c++;
    end
    check({name, "_end"}, obs(), {4'b0000, 4'(v.exp_fs)});
    @(posedge clk); #1;
    check({name, "_idle"}, obs(), {4'b0000, 4'(v.exp_fs)});
  endtask

  initial begin
    int d0;
    vecs[0] = '{cnt: 1,  abort_at: 0,     busy_start: 0,  start_abort: 0, exp_fs: 1};
    vecs[1] = '{cnt: 3,  abort_at: 0,     busy_start: 0,  start_abort: 0, exp_fs: 3};
    vecs[2] = '{cnt: 15, abort_at: 0,     busy_start: 0,  start_abort: 0, exp_fs: 15};
    vecs[3] = '{cnt: 3,  abort_at: 5 + G, busy_start: 0,  start_abort: 0, exp_fs: 1};
    vecs[4] = '{cnt: 4,  abort_at: 1,     busy_start: 0,  start_abort: 0, exp_fs: 0};
    vecs[5] = '{cnt: 2,  abort_at: 3,     busy_start: 0,  start_abort: 0, exp_fs: 0};
    vecs[6] = '{cnt: 2,  abort_at: 0,     busy_start: 2,  start_abort: 1, exp_fs: 2};
    vecs[7] = '{cnt: 1,  abort_at: 0,     busy_start: -1, start_abort: 0, exp_fs: 1};

    #1 rst = 1'b1;
    #1 check("reset_async", obs(), 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", obs(), 8'h00);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start with count=0 is ignored
    start = 1'b1;
    count = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("count_zero", obs(), {4'b0000, 4'd1});
    end
    start = 1'b0;

    // async reset during the second frame's B2
    start = 1'b1;
    count = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    count = 4'd0;
    repeat (4 + G) @(posedge clk);
    #1 check("pre_rst_b2", obs(), {4'b1110, 4'd1});
    #2 rst = 1'b1;
    #1 check("mid_rst", obs(), 8'h00);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", obs(), 8'h00);
    run_vec(vecs[0], "after_rst");

    // detector sees exactly count frames
    d0 = det_cnt;
    run_vec('{cnt: 4, abort_at: 0, busy_start: 0, start_abort: 0, exp_fs: 4}, "det_run");
    check("det_pulses", 8'(det_cnt - d0), 8'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
